// File: rtl/router_fifo_if.sv
// Byte-stream handshake between the router input FSM, one destination FIFO and its output port.
// The master side writes bytes and reads them back; the slave side is the FIFO.
interface router_fifo_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic              rd_en;
    logic              lfd_state;
    logic [DATA_W-1:0] din;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] dout;

    modport master (
        output wr_en, rd_en, lfd_state, din,
        input  full, empty, dout
    );

    modport slave (
        input  wr_en, rd_en, lfd_state, din,
        output full, empty, dout
    );
endinterface

// File: rtl/router_fifo.sv
// Per-destination 16-entry packet FIFO for the 1x3 router, with header-flag storage and a remaining-byte counter.
// Define FIFO_TRISTATE_OUT_EN to float dout when idle, so the three FIFOs can share one output bus.
module router_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           soft_rst,
    router_fifo_if.slave   bus
);
    localparam int ADDR_W = PTR_W - 1;

    logic [DATA_W:0]   mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [6:0]        pkt_cnt;
    logic              pkt_done;
    logic              out_en;
    logic [DATA_W-1:0] dout_q;
    logic              do_wr;
    logic              do_rd;
    logic [DATA_W:0]   rd_entry;

    assign bus.empty = (wr_ptr == rd_ptr);
    assign bus.full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                       (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign do_wr     = bus.wr_en && !bus.full;
    assign do_rd     = bus.rd_en && !bus.empty;
    assign rd_entry  = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (soft_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_wr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.din};
        end
    end

    // pkt_done marks that the last read finished a packet; the next idle edge releases dout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            pkt_done <= 1'b0;
            out_en   <= 1'b0;
            dout_q   <= '0;
        end else if (soft_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            pkt_done <= 1'b0;
            out_en   <= 1'b0;
            dout_q   <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= rd_entry[DATA_W-1:0];
                out_en <= 1'b1;
                if (rd_entry[DATA_W]) begin
                    pkt_cnt  <= {1'b0, rd_entry[7:2]} + 7'd1;
                    pkt_done <= 1'b0;
                end else if (pkt_cnt != 7'd0) begin
                    pkt_cnt  <= pkt_cnt - 7'd1;
                    pkt_done <= (pkt_cnt == 7'd1);
                end else begin
                    pkt_done <= 1'b0;
                end
            end else if (pkt_done) begin
                pkt_done <= 1'b0;
                out_en   <= 1'b0;
                dout_q   <= '0;
            end
        end
    end

`ifdef FIFO_TRISTATE_OUT_EN
    assign bus.dout = out_en ? dout_q : 'z;
`else
    assign bus.dout = out_en ? dout_q : '0;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Randomised and directed bench for router_fifo, checked every cycle against a queue-based packet model.
module tb_router_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic soft_rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    router_fifo_if #(.DATA_W(8)) bus ();

    router_fifo #(.DATA_W(8), .DEPTH(DEPTH), .PTR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .soft_rst (soft_rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

`ifdef FIFO_TRISTATE_OUT_EN
    logic [7:0] idle_dout = 8'bzzzz_zzzz;
`else
    logic [7:0] idle_dout = 8'h00;
`endif

    // Reference: a plain queue of {header, byte}; dout follows the packet-length rules.
    logic [8:0] model_q [$];
    logic [7:0] model_dout = 8'h00;
    bit         model_drive = 1'b0;
    int         model_remaining = 0;
    bit         model_done = 1'b0;

    task automatic model_clear();
        model_q.delete();
        model_dout      = 8'h00;
        model_drive     = 1'b0;
        model_remaining = 0;
        model_done      = 1'b0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_clear();
        end else if (soft_rst) begin
            model_clear();
        end else begin
            bit         can_rd;
            bit         can_wr;
            logic [8:0] e;
            can_rd = bus.rd_en && (model_q.size() != 0);
            can_wr = bus.wr_en && (model_q.size() != DEPTH);
            if (can_rd) begin
                e           = model_q.pop_front();
                model_dout  = e[7:0];
                model_drive = 1'b1;
                if (e[8]) begin
                    model_remaining = int'(e[7:2]) + 1;
                    model_done      = 1'b0;
                end else if (model_remaining > 0) begin
                    model_remaining = model_remaining - 1;
                    model_done      = (model_remaining == 0);
                end else begin
                    model_done = 1'b0;
                end
            end else if (model_done) begin
                model_done  = 1'b0;
                model_drive = 1'b0;
                model_dout  = 8'h00;
            end
            if (can_wr) model_q.push_back({bus.lfd_state, bus.din});
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] exp_dout;
        exp_dout = model_drive ? model_dout : idle_dout;
        check_output("cyc_empty", {7'd0, bus.empty}, {7'd0, model_q.size() == 0});
        check_output("cyc_full",  {7'd0, bus.full},  {7'd0, model_q.size() == DEPTH});
        check_output("cyc_dout",  bus.dout, exp_dout);
    end

    task automatic apply_stimulus(input logic wr, input logic rd, input logic lfd,
                                  input logic [7:0] d, input logic srst);
        bus.wr_en     = wr;
        bus.rd_en     = rd;
        bus.lfd_state = lfd;
        bus.din       = d;
        soft_rst      = srst;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pkt [15];

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.lfd_state = 1'b0; bus.din = 8'h00;

        // Reset and soft reset
        #1 rst = 1'b0;
        #10;
        check_output("rst_empty", {7'd0, bus.empty}, 8'h01);
        check_output("rst_full",  {7'd0, bus.full},  8'h00);
        check_output("rst_dout",  bus.dout, idle_dout);
        #2 rst = 1'b1;
        apply_stimulus(0, 0, 0, 8'h00, 1);
        check_output("srst_empty", {7'd0, bus.empty}, 8'h01);
        check_output("srst_full",  {7'd0, bus.full},  8'h00);
        check_output("srst_dout",  bus.dout, idle_dout);
        apply_stimulus(0, 0, 0, 8'h00, 0);

        // Single packet: header 0x34 -> 13 payload bytes + parity
        pkt[0] = 8'h34;
        for (int i = 1; i < 15; i++) pkt[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 15; i++) apply_stimulus(1, 0, (i == 0), pkt[i], 0);
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(0, 1, 0, 8'h00, 0);
            check_output("pkt_dout", bus.dout, pkt[i]);
        end
        check_output("pkt_empty", {7'd0, bus.empty}, 8'h01);
        check_output("pkt_last", bus.dout, 8'hAE);
        apply_stimulus(0, 1, 0, 8'h00, 0);
        check_output("pkt_end_dout", bus.dout, idle_dout);
        apply_stimulus(0, 0, 0, 8'h00, 0);

        // Fill to full, then one dropped write
        for (int i = 0; i < 16; i++) apply_stimulus(1, 0, 0, 8'(i), 0);
        check_output("fill_full", {7'd0, bus.full}, 8'h01);
        apply_stimulus(1, 0, 0, 8'hFF, 0);
        check_output("fill_full_hold", {7'd0, bus.full}, 8'h01);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(0, 1, 0, 8'h00, 0);
            check_output("fill_dout", bus.dout, 8'(i));
        end
        check_output("fill_empty", {7'd0, bus.empty}, 8'h01);

        // Wrap and simultaneous access
        for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, 8'h40 + 8'(i), 0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, 1, 0, 8'h00, 0);
            check_output("wrap_pre_dout", bus.dout, 8'h40 + 8'(i));
        end
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1, 1, 0, 8'h60 + 8'(i), 0);
            check_output("wrap_empty", {7'd0, bus.empty}, 8'h00);
            if (i > 0) check_output("wrap_dout", bus.dout, 8'h60 + 8'(i - 1));
        end
        apply_stimulus(0, 1, 0, 8'h00, 0);
        check_output("wrap_tail", bus.dout, 8'h73);

        // Soft reset mid-packet wins over a concurrent write
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, (i == 0), 8'h50 + 8'(i), 0);
        apply_stimulus(1, 0, 0, 8'hEE, 1);
        check_output("srst_mid_empty", {7'd0, bus.empty}, 8'h01);
        check_output("srst_mid_dout", bus.dout, idle_dout);
        apply_stimulus(1, 0, 0, 8'h11, 0);
        apply_stimulus(0, 1, 0, 8'h00, 0);
        check_output("srst_after", bus.dout, 8'h11);
        check_output("srst_after_empty", {7'd0, bus.empty}, 8'h01);

        // Async reset between edges during a read burst
        for (int i = 0; i < 8; i++) apply_stimulus(1, 0, 0, 8'h80 + 8'(i), 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 8'h00, 0);
        check_output("arst_pre", bus.dout, 8'h82);
        #3 rst = 1'b0;
        #1;
        check_output("arst_full",  {7'd0, bus.full},  8'h00);
        check_output("arst_empty", {7'd0, bus.empty}, 8'h01);
        check_output("arst_dout",  bus.dout, idle_dout);
        #2 rst = 1'b1;
        apply_stimulus(0, 0, 0, 8'h00, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            apply_stimulus(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                           ($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 63) == 0));
        end
        apply_stimulus(0, 0, 0, 8'h00, 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
